io_pads_filtered: RTL and testbench

//  Next-generation Caravel pad interface for the CPU cores. Maps IO_PINS logical pins onto pads FIRST_PAD..,

---
 rtl/io_pads_filtered.sv | 137 +++++++++++++
 tb/tb_io_pads_filtered.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_pads_filtered.sv
// Caravel pad interface: maps logical pins onto user pads, synchronises and glitch-filters inputs,
// latches sticky edge flags with a maskable interrupt, configured through a small register file.
module io_pads_filtered #(
  parameter int IO_PINS     = 16,
  parameter int IO_PADS     = 38,
  parameter int FIRST_PAD   = 12,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [IO_PADS-1:0] io_in,
  output logic [IO_PADS-1:0] io_out,
  output logic [IO_PADS-1:0] io_oeb,
  output logic               rst_soft_n,
  output logic [IO_PINS-1:0] pin_dir,
  output logic [IO_PINS-1:0] pin_data_in,
  input  logic [IO_PINS-1:0] pin_data_out,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [IO_PINS-1:0] cfg_wdata,
  output logic [IO_PINS-1:0] cfg_rdata,
  output logic               edge_irq
);

  localparam logic [2:0] ADDR_PROG     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_FILT_EN  = 3'd2;
  localparam logic [2:0] ADDR_FLAGS    = 3'd3;
  localparam logic [2:0] ADDR_FILT_LEN = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
  localparam logic [2:0] ADDR_STATE    = 3'd6;

  localparam logic [IO_PADS-1:0] PIN_MASK = IO_PADS'({IO_PINS{1'b1}}) << FIRST_PAD;

  logic                            programming;
  logic [IO_PINS-1:0]              saved_dir;
  logic [IO_PINS-1:0]              filt_en;
  logic [IO_PINS-1:0]              edge_flags;
  logic [FILT_W-1:0]               filt_len;
  logic [IO_PINS-1:0]              irq_mask;

  logic [IO_PINS-1:0]              sync_q [SYNC_STAGES];
  logic [IO_PINS-1:0]              s;
  logic [IO_PINS-1:0]              f_q, f_next;
  logic [IO_PINS-1:0][FILT_W-1:0]  cnt_q, cnt_next;
  logic [IO_PINS-1:0]              edge_set, edge_clr;
  logic                            unused_pads;

  // Pads outside the pin window are never sampled.
  assign unused_pads = ^(io_in & ~PIN_MASK);

  assign rst_soft_n  = !wb_rst_i && !programming;
  assign pin_dir     = programming ? '0 : saved_dir;
  assign pin_data_in = f_q & ~pin_dir;
  assign s           = sync_q[SYNC_STAGES-1];

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    io_out[FIRST_PAD +: IO_PINS] = pin_dir & pin_data_out;
    io_oeb[FIRST_PAD +: IO_PINS] = ~pin_dir;
  end

  // Glitch filter: a differing sample must persist filt_len cycles before f accepts it.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    f_next   = f_q;
    cnt_next = '0;
    for (int i = 0; i < IO_PINS; i++) begin
      if (!filt_en[i] || filt_len == '0) begin
        f_next[i] = s[i];
      end else if (s[i] != f_q[i]) begin
        if (cnt_q[i] >= filt_len - FILT_W'(1)) f_next[i] = s[i];
        else                                  cnt_next[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  assign edge_set = (f_next ^ f_q) & ~pin_dir;
  assign edge_clr = (cfg_we && cfg_addr == ADDR_FLAGS) ? cfg_wdata : '0;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      f_q   <= '0;
      cnt_q <= '0;
    end else begin
      sync_q[0] <= io_in[FIRST_PAD +: IO_PINS];
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      f_q   <= f_next;
      cnt_q <= cnt_next;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      programming <= 1'b0;
      saved_dir   <= '0;
      filt_en     <= '0;
      edge_flags  <= '0;
      filt_len    <= '0;
      irq_mask    <= '0;
      edge_irq    <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_PROG:     programming <= cfg_wdata[0];
          ADDR_DIR:      saved_dir   <= cfg_wdata;
          ADDR_FILT_EN:  filt_en     <= cfg_wdata;
          ADDR_FILT_LEN: filt_len    <= cfg_wdata[FILT_W-1:0];
          ADDR_IRQ_MASK: irq_mask    <= cfg_wdata;
          default: ;
        endcase
      end
      // A new edge wins over a simultaneous W1C clear.
      edge_flags <= (edge_flags & ~edge_clr) | edge_set;
      edge_irq   <= |(edge_flags & irq_mask);
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_PROG:     cfg_rdata = IO_PINS'(programming);
      ADDR_DIR:      cfg_rdata = saved_dir;
      ADDR_FILT_EN:  cfg_rdata = filt_en;
      ADDR_FLAGS:    cfg_rdata = edge_flags;
      ADDR_FILT_LEN: cfg_rdata = IO_PINS'(filt_len);
      ADDR_IRQ_MASK: cfg_rdata = irq_mask;
      ADDR_STATE:    cfg_rdata = f_q;
      default:       cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_io_pads_filtered.sv
// Scoreboard bench for io_pads_filtered: stimulus queues cycle-tagged expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_io_pads_filtered;

  localparam int SEL_OEB   = 0;
  localparam int SEL_OUT   = 1;
  localparam int SEL_DIR   = 2;
  localparam int SEL_DIN   = 3;
  localparam int SEL_IRQ   = 4;
  localparam int SEL_SOFT  = 5;
  localparam int SEL_RDATA = 6;

  typedef struct {
    int          cyc;
    int          sel;
    logic [37:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [37:0] io_in = '0;
  logic [37:0] io_out, io_oeb;
  logic        rst_soft_n;
  logic [15:0] pin_dir, pin_data_in;
  logic [15:0] pin_data_out = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] cfg_rdata;
  logic        edge_irq;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  io_pads_filtered dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb),
    .rst_soft_n   (rst_soft_n),
    .pin_dir      (pin_dir),
    .pin_data_in  (pin_data_in),
    .pin_data_out (pin_data_out),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .edge_irq     (edge_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [37:0] observe(input int sel);
    case (sel)
      SEL_OEB:   return io_oeb;
      SEL_OUT:   return io_out;
      SEL_DIR:   return 38'(pin_dir);
      SEL_DIN:   return 38'(pin_data_in);
      SEL_IRQ:   return 38'(edge_irq);
      SEL_SOFT:  return 38'(rst_soft_n);
      default:   return 38'(cfg_rdata);
    endcase
  endfunction

  task automatic check(input exp_t e);
    logic [37:0] got;
    got = observe(e.sel);
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, got, e.exp, e.cyc);
    end
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        check(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input int sel, input logic [37:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sel  = sel;
    e.exp  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick(1);
    cfg_we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] d, input string name);
    cfg_addr = a;
    expect_at(0, SEL_RDATA, 38'(d), name);
    tick(1);
  endtask

  initial begin
    int c;
    tick(3);
    expect_at(0, SEL_OEB,  {38{1'b1}}, "reset_oeb");
    expect_at(0, SEL_OUT,  '0,         "reset_out");
    expect_at(0, SEL_DIR,  '0,         "reset_dir");
    expect_at(0, SEL_DIN,  '0,         "reset_din");
    expect_at(0, SEL_IRQ,  '0,         "reset_irq");
    expect_at(0, SEL_SOFT, '0,         "reset_soft_n");
    tick(1);
    rst = 1'b0;
    expect_at(0, SEL_SOFT, 38'd1, "release_soft_n");
    tick(1);

    // Direction and output mapping.
    wr(3'd1, 16'h00FF);
    pin_data_out = 16'h0F0F;
    expect_at(0, SEL_OEB, {10'h3FF, 16'hFF00, 12'hFFF}, "dir_oeb");
    expect_at(0, SEL_OUT, {10'h000, 16'h000F, 12'h000}, "dir_out");
    expect_at(0, SEL_DIR, 38'h00FF, "dir_pin_dir");
    rd(3'd1, 16'h00FF, "rd_saved_dir");

    // Unfiltered latency on pad 20 / pin 8.
    io_in[20] = 1'b1;
    expect_at(2, SEL_DIN, 38'h0000, "lat_early");
    expect_at(3, SEL_DIN, 38'h0100, "lat_exact");
    tick(4);
    io_in[20] = 1'b0;
    tick(5);
    wr(3'd1, 16'h0000);
    wr(3'd3, 16'hFFFF);
    rd(3'd3, 16'h0000, "flags_cleared");

    // Filter on pin 0, length 4.
    wr(3'd2, 16'h0001);
    wr(3'd4, 16'h0004);
    rd(3'd4, 16'h0004, "rd_filt_len");
    rd(3'd2, 16'h0001, "rd_filt_en");
    io_in[12] = 1'b1;
    expect_at(4, SEL_DIN, 38'h0, "short_pulse_a");
    expect_at(6, SEL_DIN, 38'h0, "short_pulse_b");
    expect_at(8, SEL_DIN, 38'h0, "short_pulse_c");
    tick(3);
    io_in[12] = 1'b0;
    tick(8);
    rd(3'd3, 16'h0000, "short_pulse_no_flag");

    io_in[12] = 1'b1;
    expect_at(5, SEL_DIN, 38'h0, "long_pulse_before");
    expect_at(6, SEL_DIN, 38'h1, "long_pulse_accept");
    tick(6);
    rd(3'd3, 16'h0001, "long_pulse_flag");
    expect_at(0, SEL_IRQ, 38'd0, "irq_masked");

    // Interrupt and write-one-to-clear.
    wr(3'd5, 16'h0001);
    expect_at(0, SEL_IRQ, 38'd0, "irq_mask_lag");
    expect_at(1, SEL_IRQ, 38'd1, "irq_set");
    tick(2);
    wr(3'd3, 16'h0001);
    expect_at(0, SEL_IRQ, 38'd1, "irq_before_clear");
    expect_at(1, SEL_IRQ, 38'd0, "irq_cleared");
    rd(3'd3, 16'h0000, "w1c_flag");
    rd(3'd6, 16'h0001, "rd_state");

    // Falling edge accepted in the same cycle as a clear: set wins.
    c = cyc;
    io_in[12] = 1'b0;
    expect_at(5, SEL_DIN, 38'h1, "fall_before");
    expect_at(6, SEL_DIN, 38'h0, "fall_accept");
    expect_at(6, SEL_IRQ, 38'd0, "irq_before_collide");
    tick(5);
    wr(3'd3, 16'h0001);
    expect_at(1, SEL_IRQ, 38'd1, "irq_after_collide");
    rd(3'd3, 16'h0001, "collide_flag_kept");

    // Programming mode overrides direction.
    wr(3'd1, 16'hFFFF);
    expect_at(0, SEL_DIR, 38'hFFFF, "dir_all_out");
    wr(3'd0, 16'h0001);
    expect_at(0, SEL_SOFT, 38'd0,       "prog_soft_n");
    expect_at(0, SEL_DIR,  38'h0,       "prog_dir");
    expect_at(0, SEL_OEB,  {38{1'b1}},  "prog_oeb");
    expect_at(0, SEL_OUT,  '0,          "prog_out");
    rd(3'd1, 16'hFFFF, "prog_saved_dir_kept");
    wr(3'd0, 16'h0000);
    expect_at(0, SEL_SOFT, 38'd1, "unprog_soft_n");
    expect_at(0, SEL_DIR,  38'hFFFF, "unprog_dir");
    expect_at(0, SEL_OEB,  {10'h3FF, 16'h0000, 12'hFFF}, "unprog_oeb");
    expect_at(0, SEL_OUT,  {10'h000, 16'h0F0F, 12'h000}, "unprog_out");
    tick(1);

    // Asynchronous reset mid-traffic.
    io_in[12] = 1'b1;
    tick(2);
    #2;
    rst = 1'b1;
    expect_at(0, SEL_OEB,  {38{1'b1}}, "midrst_oeb");
    expect_at(0, SEL_OUT,  '0,         "midrst_out");
    expect_at(0, SEL_DIR,  '0,         "midrst_dir");
    expect_at(0, SEL_IRQ,  '0,         "midrst_irq");
    expect_at(0, SEL_SOFT, '0,         "midrst_soft_n");
    for (int a = 0; a < 7; a++) rd(3'(a), 16'h0000, $sformatf("midrst_reg%0d", a));

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    while (sb.size() > 0) begin
      errors++;
      $display("FAIL %s: expectation never compared (cycle %0d)", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
